// File: rtl/lb_pkg.sv
// Shared types and helpers for the slow-control local bus arbiter.
// Holds bus widths, the sequencer state encoding and the rotating-priority pick.
package lb_pkg;

    localparam int LB_AW   = 8;
    localparam int LB_DW   = 32;
    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STROBE = 3'd1,
        WAIT   = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } lb_state_e;

    // Returns {found, index}: the first set request at or after ptr, wrapping modulo n.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [3:0] res;
        logic [2:0] k;
        res = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                k = 3'((int'(ptr) + i) % n);
                if (req[k]) res = {1'b1, k};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lb_arbiter_if.sv
// Master-side request/done signals and local-bus signals of the arbiter.
// A master raises req_i (with we_i/addr_i/wdata_i stable) and holds it until its one-cycle done_o pulse;
// gnt_o marks the owner from grant to done, and rdata_o is valid in the done_o cycle of a read.
interface lb_arbiter_if #(
    parameter int NREQ = 2
);
    import lb_pkg::*;

    logic [NREQ-1:0]       req_i;
    logic [NREQ-1:0]       we_i;
    logic [NREQ*LB_AW-1:0] addr_i;
    logic [NREQ*LB_DW-1:0] wdata_i;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ-1:0]       done_o;
    logic [LB_DW-1:0]      rdata_o;
    logic                  busy_o;
    logic [LB_AW-1:0]      lb_addr_o;
    logic [LB_DW-1:0]      lb_wdata_o;
    logic                  lb_write_o;
    logic                  lb_read_o;
    logic [LB_DW-1:0]      lb_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, lb_rdata_i,
        output gnt_o, done_o, rdata_o, busy_o, lb_addr_o, lb_wdata_o, lb_write_o, lb_read_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, lb_rdata_i,
        input  gnt_o, done_o, rdata_o, busy_o, lb_addr_o, lb_wdata_o, lb_write_o, lb_read_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first request at or after the pointer wins.
module rr_arbiter
    import lb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [MAX_REQ-1:0] w_req;
    logic [2:0]         w_ptr;
    logic [3:0]         w_pick;

    always_comb begin
        w_req             = '0;
        w_req[N-1:0]      = i_req;
        w_ptr             = '0;
        w_ptr[IW-1:0]     = i_ptr;
        w_pick            = rr_pick(w_req, w_ptr, N);
        o_any             = w_pick[3];
        o_idx             = w_pick[IW-1:0];
        o_gnt             = '0;
        if (w_pick[3]) o_gnt[w_pick[IW-1:0]] = 1'b1;
    end

endmodule

// File: rtl/lb_arbiter.sv
// Round-robin arbiter sharing the 0x90xx slow-control local bus between NREQ masters.
// Sequences each transaction as grant, one strobe, read-latency or write-gap wait, then a done pulse.
module lb_arbiter
    import lb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int RD_LAT = 2,
    parameter int WR_GAP = 1
) (
    input  logic        clk_100_i,
    input  logic        reset_i,
    lb_arbiter_if.slave bus,
    output lb_state_e   dbg_state_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 4;

    lb_state_e        r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_idx;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic             r_we;
    logic [CW-1:0]    r_cnt;
    logic [LB_AW-1:0] r_addr;
    logic [LB_DW-1:0] r_wdata;
    logic [LB_DW-1:0] r_rdata;
    logic             r_busy;
    logic             r_wr;
    logic             r_rd;

    logic [NREQ-1:0]  w_gnt;
    logic [IW-1:0]    w_idx;
    logic             w_any;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .i_req (bus.req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk_100_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_done <= '0;
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= STROBE;
                        r_busy  <= 1'b1;
                        r_gnt   <= w_gnt;
                        r_idx   <= w_idx;
                        r_we    <= bus.we_i[w_idx];
                        r_addr  <= bus.addr_i[int'(w_idx)*LB_AW +: LB_AW];
                        r_wdata <= bus.wdata_i[int'(w_idx)*LB_DW +: LB_DW];
                    end
                end
                // The strobe register is loaded here, so the pulse lands one cycle after the
                // grant with address and data already settled on the bus.
                STROBE: begin
                    r_cnt <= '0;
                    if (r_we) begin
                        r_wr    <= 1'b1;
                        r_state <= GAP;
                    end else begin
                        r_rd    <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == CW'(RD_LAT)) begin
                        r_rdata <= bus.lb_rdata_i;
                        r_done  <= r_gnt;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == CW'(WR_GAP)) begin
                        r_done  <= r_gnt;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    r_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_o      = r_gnt;
    assign bus.done_o     = r_done;
    assign bus.rdata_o    = r_rdata;
    assign bus.busy_o     = r_busy;
    assign bus.lb_addr_o  = r_addr;
    assign bus.lb_wdata_o = r_wdata;
    assign bus.lb_write_o = r_wr;
    assign bus.lb_read_o  = r_rd;
    assign dbg_state_o    = r_state;

endmodule
